arbitro_escritura_banco: RTL

Write-port arbiter and pending-write scoreboard for the 32×32 register file `banco_registros`. Two writeback sources compete for the single write port: the ALU result path and the load (memory) path. The block grants one of them per cycle under round-robin priority and drives `writeReg`/`writeData`/`RegWrite` from a registered output stage. It also keeps a busy bit per register so the issue stage can detect RAW hazards.

---
 rtl/arbitro_escritura_banco_pkg.sv | 12 +
 rtl/arbitro_escritura_banco_marcador.sv | 42 ++++
 rtl/arbitro_escritura_banco.sv | 95 +++++++++
 3 files changed

// File: rtl/arbitro_escritura_banco_pkg.sv
// Shared constants and types for the register-file write path.
package pkg_banco_registros;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef logic [AW-1:0] reg_idx_t;

  typedef enum logic {PRI_ALU, PRI_MEM} prio_t;

endpackage

// File: rtl/arbitro_escritura_banco_marcador.sv
// Busy-bit scoreboard: one pending-write bit per register plus a two-port hazard lookup.
module marcador_registros
  import pkg_banco_registros::*;
#(
  parameter int NREG = pkg_banco_registros::NREG,
  parameter int AW   = pkg_banco_registros::AW
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            setValid,
  input  logic [AW-1:0]   setReg,
  input  logic            clrValid,
  input  logic [AW-1:0]   clrReg,
  input  logic [AW-1:0]   chkReg1,
  input  logic [AW-1:0]   chkReg2,
  output logic [NREG-1:0] busy,
  output logic            hazard
);

  logic [NREG-1:0] setMask;
  logic [NREG-1:0] clrMask;
  logic [NREG-1:0] busyNext;

  // Set is applied after clear so a same-edge reserve and commit leaves the bit set.
  always_comb begin
    setMask     = {{(NREG-1){1'b0}}, setValid} << setReg;
    clrMask     = {{(NREG-1){1'b0}}, clrValid} << clrReg;
    busyNext    = (busy & ~clrMask) | setMask;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  assign hazard = busy[chkReg1] | busy[chkReg2];

endmodule

// File: rtl/arbitro_escritura_banco.sv
// Round-robin arbiter between the ALU and load writeback paths, with a registered
// write-port stage feeding banco_registros and the pending-write scoreboard.
module arbitro_escritura_banco
  import pkg_banco_registros::*;
#(
  parameter int NREG = pkg_banco_registros::NREG,
  parameter int AW   = pkg_banco_registros::AW,
  parameter int DW   = pkg_banco_registros::DW
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_reg,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_reg,
  input  logic [DW-1:0]   mem_data,
  output logic            mem_ready,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_reg,
  input  logic [AW-1:0]   chk_reg1,
  input  logic [AW-1:0]   chk_reg2,
  output logic            hazard,
  output logic [NREG-1:0] busy,
  output logic [AW-1:0]   writeReg,
  output logic [DW-1:0]   writeData,
  output logic            RegWrite
);

  prio_t         priState;
  prio_t         priNext;
  logic          rsvValidEff;
  logic [AW-1:0] winReg;
  logic [DW-1:0] winData;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      priState <= PRI_ALU;
    end else begin
      priState <= priNext;
    end
  end

  // A lone requester always wins; under contention the pointer holder wins.
  // Whoever wins hands priority to the other source.
  always_comb begin
    alu_ready = alu_valid & (~mem_valid | (priState == PRI_ALU));
    mem_ready = mem_valid & (~alu_valid | (priState == PRI_MEM));
    priNext   = priState;
    winReg    = alu_reg;
    winData   = alu_data;
    if (alu_ready) begin
      priNext = PRI_MEM;
    end else if (mem_ready) begin
      priNext = PRI_ALU;
      winReg  = mem_reg;
      winData = mem_data;
    end
  end

  // Writes to x0 are acknowledged but never reach the bank.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (alu_ready || mem_ready) begin
      RegWrite  <= (winReg != '0);
      writeReg  <= winReg;
      writeData <= winData;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  assign rsvValidEff = rsv_valid & (rsv_reg != '0);

  marcador_registros #(
    .NREG(NREG),
    .AW  (AW)
  ) marcador (
    .CLK     (CLK),
    .RESET   (RESET),
    .setValid(rsvValidEff),
    .setReg  (rsv_reg),
    .clrValid(RegWrite),
    .clrReg  (writeReg),
    .chkReg1 (chk_reg1),
    .chkReg2 (chk_reg2),
    .busy    (busy),
    .hazard  (hazard)
  );

endmodule
